// File: rtl/cmp_pkg.sv
// Shared types and helpers for the nibble-serial magnitude compare sequencer.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int NIBBLE_W = 4;
   // Widest operand the nibble selector accepts; callers zero-extend into it.
   localparam int MAX_W    = 256;

   function automatic logic [NIBBLE_W-1:0] get_nibble(input logic [MAX_W-1:0] vec,
                                                      input int unsigned      idx);
      logic [MAX_W-1:0] shifted;
      shifted = vec >> (idx * NIBBLE_W);
      return shifted[NIBBLE_W-1:0];
   endfunction

endpackage

// File: rtl/nibble_cmp.sv
// Combinational 4-bit unsigned magnitude comparator, the single shared compare resource.
module nibble_cmp
   import cmp_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   output logic                eq,
   output logic                gr,
   output logic                less
);

   assign eq   = (a == b);
   assign gr   = (a >  b);
   assign less = (a <  b);

endmodule

// File: rtl/nibble_serial_cmp_ctrl.sv
// Compares two WIDTH-bit unsigned operands one nibble per cycle, MSB nibble first,
// stopping at the first differing nibble; start/done handshake around a 4-bit comparator.
//
// state | meaning
// IDLE  | waiting for start; last result flags held
// CMP   | one nibble compared per cycle, idx counts down to 0
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module nibble_serial_cmp_ctrl
   import cmp_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int NIBBLES = WIDTH / 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gr,
   output logic             less
);

   localparam int IDX_W = $clog2(NIBBLES);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               eq_q, eq_d;
   logic               gr_q, gr_d;
   logic               less_q, less_d;

   logic [NIBBLE_W-1:0] nib_a, nib_b;
   logic                c_eq, c_gr, c_less;

   assign nib_a = get_nibble(MAX_W'(a_q), 32'(idx_q));
   assign nib_b = get_nibble(MAX_W'(b_q), 32'(idx_q));

   nibble_cmp u_nibble_cmp (
      .a    (nib_a),
      .b    (nib_b),
      .eq   (c_eq),
      .gr   (c_gr),
      .less (c_less)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         eq_q    <= 1'b0;
         gr_q    <= 1'b0;
         less_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         eq_q    <= eq_d;
         gr_q    <= gr_d;
         less_q  <= less_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      eq_d    = eq_q;
      gr_d    = gr_q;
      less_d  = less_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               idx_d   = IDX_W'(NIBBLES - 1);
               eq_d    = 1'b0;
               gr_d    = 1'b0;
               less_d  = 1'b0;
               state_d = CMP;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         CMP: begin
            if (c_gr) begin
               gr_d    = 1'b1;
               state_d = DONE;
            end else if (c_less) begin
               less_d  = 1'b1;
               state_d = DONE;
            end else if (c_eq && (idx_q == '0)) begin
               eq_d    = 1'b1;
               state_d = DONE;
            end else begin
               // Scan ends at idx 0, so the decrement never wraps.
               idx_d = idx_q - IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == CMP);
   assign done = (state_q == DONE);
   assign eq   = eq_q;
   assign gr   = gr_q;
   assign less = less_q;

endmodule

// File: tb/tb_nibble_serial_cmp_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, compared cycle by cycle
// against a transaction-level model (latency and result derived from operand nibbles).
module tb_nibble_serial_cmp_ctrl;

   localparam int WIDTH   = 16;
   localparam int NIBBLES = WIDTH / 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy, done, eq, gr, less;

   int n_checks;
   int n_fail;

   // reference model state
   int  m_remaining;
   bit  m_done;
   bit  m_eq, m_gr, m_less;
   bit  p_eq, p_gr, p_less;

   nibble_serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .eq    (eq),
      .gr    (gr),
      .less  (less)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Nibbles examined and outcome, from the scan-from-the-top rule.
   function automatic void expect_of(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                     output int n, output bit r_eq, output bit r_gr,
                                     output bit r_less);
      int na, nb;
      r_eq = 0; r_gr = 0; r_less = 0; n = NIBBLES;
      for (int i = NIBBLES - 1; i >= 0; i--) begin
         na = int'((av >> (4 * i)) & 16'hF);
         nb = int'((bv >> (4 * i)) & 16'hF);
         if (na != nb) begin
            n = NIBBLES - i;
            r_gr = (na > nb);
            r_less = (na < nb);
            return;
         end
      end
      r_eq = 1;
   endfunction

   task automatic model_edge();
      int n;
      if (rst) begin
         m_remaining = 0; m_done = 0;
         m_eq = 0; m_gr = 0; m_less = 0;
      end else if (m_remaining > 0) begin
         m_remaining--;
         m_done = (m_remaining == 0);
         if (m_done) begin
            m_eq = p_eq; m_gr = p_gr; m_less = p_less;
         end
      end else if (start) begin
         expect_of(a, b, n, p_eq, p_gr, p_less);
         m_remaining = n;
         m_done = 0;
         m_eq = 0; m_gr = 0; m_less = 0;
      end else begin
         m_done = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("busy", 32'(busy), 32'(m_remaining > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("eq",   32'(eq),   32'(m_eq));
      chk("gr",   32'(gr),   32'(m_gr));
      chk("less", 32'(less), 32'(m_less));
   endtask

   task automatic drive(input bit st, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input bit r);
      start = st; a = av; b = bv; rst = r;
      tick();
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) drive(1'b0, a, b, 1'b0);
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      int k;
      n_checks = 0; n_fail = 0;
      m_remaining = 0; m_done = 0; m_eq = 0; m_gr = 0; m_less = 0;
      p_eq = 0; p_gr = 0; p_less = 0;
      rst = 1'b1; start = 1'b1; a = '0; b = '0;

      // reset held with start asserted
      drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
      drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
      drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("state_idle_after_reset", 32'(dut.state_q), 32'd0);

      // equal operands, full-length scan
      drive(1'b1, 16'h1234, 16'h1234, 1'b0);
      idle(6);

      // MSB nibble differs, then all-zero equal
      drive(1'b1, 16'hA000, 16'hD000, 1'b0);
      idle(2);
      drive(1'b1, 16'h0000, 16'h0000, 1'b0);
      idle(6);

      // third nibble decides
      drive(1'b1, 16'h12F4, 16'h12E9, 1'b0);
      idle(5);

      // operand change and start pulse while busy are ignored
      drive(1'b1, 16'h5555, 16'h5554, 1'b0);
      drive(1'b1, 16'h0000, 16'h5554, 1'b0);
      idle(8);

      // abort mid-compare
      drive(1'b1, 16'h0000, 16'h0001, 1'b0);
      drive(1'b0, 16'h0000, 16'h0001, 1'b0);
      drive(1'b0, 16'h0000, 16'h0001, 1'b1);
      idle(3);

      // back-to-back: start held in the DONE cycle
      drive(1'b1, 16'h0001, 16'h0000, 1'b0);
      idle(3);
      drive(1'b0, 16'h0001, 16'h0000, 1'b0);
      chk("done_before_b2b", 32'(done), 32'd1);
      drive(1'b1, 16'h0F00, 16'h0F00, 1'b0);
      chk("b2b_accepted_busy", 32'(busy), 32'd1);
      idle(6);

      // random traffic
      for (int c = 0; c < 600; c++) begin
         ra = WIDTH'($urandom);
         rb = ra;
         k = $urandom_range(0, NIBBLES);
         if (k < NIBBLES) rb[k*4 +: 4] = 4'($urandom);
         if ($urandom_range(0, 3) == 0) rb = WIDTH'($urandom);
         drive(($urandom_range(0, 9) < 4), ra, rb, ($urandom_range(0, 59) == 0));
      end
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nibble_serial_cmp_ctrl.md
Name: nibble_serial_cmp_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands using one shared 4-bit magnitude comparator, one nibble per cycle.
- Scans from the most significant nibble down to the least significant, and stops at the first nibble that differs.
- Sits beside the 4-bit comparator datapath and gives wide operands a start/done handshake.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived nibble count; not overridden.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous, active-high reset
- start  input   1      request a compare; sampled only when not busy
- a      input   WIDTH  operand A; captured on an accepted start
- b      input   WIDTH  operand B; captured on an accepted start
- busy   output  1      high while in CMP
- done   output  1      one-cycle pulse when a result is valid
- eq     output  1      result flag: A == B
- gr     output  1      result flag: A > B
- less   output  1      result flag: A < B

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: state goes to IDLE. busy, done, eq, gr, less all 0. Nibble index and operand registers are cleared.
- States:
  - IDLE: busy=0. On start, capture a and b, set idx=NIBBLES-1, clear eq/gr/less, go to CMP.
  - CMP: busy=1. Drive the comparator with a_q[idx] and b_q[idx].
    - Comparator gr: register gr=1 and go to DONE.
    - Comparator less: register less=1 and go to DONE.
    - Comparator eq and idx==0: register eq=1 and go to DONE.
    - Otherwise: idx decrements and state stays CMP.
  - DONE: done=1 for exactly this cycle; busy=0.
    - start here is accepted like in IDLE (back-to-back), going straight to CMP.
    - With no start, go to IDLE.
- Latency: start sampled at edge E0. done and the result flags become valid at edge E0+N, where N is the number of nibbles examined (1..NIBBLES).
  - Worst case (equal operands) is NIBBLES cycles.
- Result holding:
  - Exactly one of eq/gr/less is high from done until the next accepted start, which clears all three.
  - Flags stay valid through IDLE.
- Operand isolation: a and b are ignored except on the accepting edge. Changes during CMP do not affect the result.
- Start while busy: ignored, with no queueing.
- Reset mid-operation: the compare is aborted with no done pulse, and all outputs go to 0 on the next edge.
- Reset and start together: reset wins.
- Arithmetic: unsigned only. idx is $clog2(NIBBLES) bits wide and never wraps below 0, because the idx==0 check terminates the scan.

Decomposition:
- Shared package cmp_pkg holds:
  - state enum {IDLE, CMP, DONE};
  - NIBBLE_W = 4;
  - a function selecting nibble idx of a WIDTH vector.
- One sub-module, nibble_cmp: purely combinational 4-bit comparator with ports a[3:0], b[3:0], eq, gr, less. It is instantiated once and is the shared resource.
- The FSM, index counter, operand registers and result registers live in the top level.

Test Plan:
All scenarios use WIDTH=16.
- Reset: hold rst 2 cycles with start=1. Expect busy=done=eq=gr=less=0 throughout, and IDLE after release.
- Equal operands: a=0x1234, b=0x1234, start pulse. Expect busy for 4 cycles, then done at E0+4 with eq=1, gr=0, less=0.
- MSB-nibble difference: a=0xA000, b=0xD000 (1010 vs 1101). Expect done at E0+1 with less=1; a=0x0000, b=0x0000 afterwards gives eq at E0+4.
- Mid-nibble difference: a=0x12F4, b=0x12E9. Expect done at E0+3 with gr=1, eq=0, less=0.
- Isolation and ignore:
  - Start a=0x5555, b=0x5554.
  - During busy, pulse start and change a to 0x0000.
  - Expect a single done at E0+4 with gr=1, and no second transaction.
- Abort and back-to-back:
  - Start a=0x0000, b=0x0001 and assert rst at E0+2. Expect no done and all outputs 0.
  - Then start a=0x0001, b=0x0000, and hold start high during the DONE cycle with a=0x0F00, b=0x0F00.
  - Expect gr done at E0+4, the second compare accepted in the DONE cycle, and an eq done 4 cycles later.
